serial_fa_sequencer: RTL and testbench

- Bit-serial operand sequencer that sits directly upstream and downstream of the single-bit full adder (FA).
- Accepts a WIDTH-bit addition request (A, B, carry-in) over a valid/ready handshake.
- Feeds the FA one bit pair per cycle, LSB first, with the carry looped back through a register.
- Collects the FA sum bits into a WIDTH-bit result with carry-out, presented on a valid/ready output handshake.

---
 rtl/serial_fa_sequencer_if.sv | 34 +++
 rtl/serial_fa_sequencer.sv | 94 +++++++++
 tb/tb_serial_fa_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/serial_fa_sequencer_if.sv
// Handshake and FA-side bundle for the bit-serial adder sequencer.
// slave = sequencer view, master = requester/consumer/FA view.
interface serial_fa_sequencer_if #(
  parameter int WIDTH = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             fa_a;
  logic             fa_b;
  logic             fa_cin;
  logic             fa_s;
  logic             fa_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;

  modport slave (
    input  in_valid, in_a, in_b, in_cin,
    input  fa_s, fa_cout, out_ready,
    output in_ready, fa_a, fa_b, fa_cin,
    output out_valid, out_sum, out_cout
  );

  modport master (
    output in_valid, in_a, in_b, in_cin,
    output fa_s, fa_cout, out_ready,
    input  in_ready, fa_a, fa_b, fa_cin,
    input  out_valid, out_sum, out_cout
  );
endinterface

// File: rtl/serial_fa_sequencer.sv
// Bit-serial add sequencer around an external single-bit full adder.
// LSB-first operand feed, carry looped through a register.
module serial_fa_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_fa_sequencer_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_next;
  logic             run;

  // New sum bit enters from the MSB side; after WIDTH shifts bit i is sum bit i.
  assign sum_next = {bus.fa_s, sum_sh};
  assign run      = (state == RUN);

  assign bus.in_ready = (state == IDLE);

  // FA inputs are only driven while a request is being serialised.
  always_comb begin
    bus.fa_a   = 1'b0;
    bus.fa_b   = 1'b0;
    bus.fa_cin = 1'b0;
    if (run) begin
      bus.fa_a   = a_sh[0];
      bus.fa_b   = b_sh[0];
      bus.fa_cin = carry;
    end
  end

  // Control FSM with operand/sum shifters and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      a_sh          <= '0;
      b_sh          <= '0;
      sum_sh        <= '0;
      carry         <= 1'b0;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh  <= bus.in_a;
            b_sh  <= bus.in_b;
            carry <= bus.in_cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_sh <= sum_next[WIDTH-1:1];
          carry  <= bus.fa_cout;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            bus.out_sum   <= sum_next;
            bus.out_cout  <= bus.fa_cout;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          bus.out_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_fa_sequencer.sv
// Directed bench for serial_fa_sequencer (WIDTH=4) with a behavioural FA.
// Table-driven adds plus backpressure, mid-RUN and reset sequences.
module tb_serial_fa_sequencer;
  localparam int W = 4;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  serial_fa_sequencer_if #(.WIDTH(W)) bus ();

  serial_fa_sequencer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural full adder on the fa_* loop.
  assign bus.fa_s    = bus.fa_a ^ bus.fa_b ^ bus.fa_cin;
  assign bus.fa_cout = (bus.fa_a & bus.fa_b) |
                       (bus.fa_a & bus.fa_cin) |
                       (bus.fa_b & bus.fa_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic [W-1:0] cseq;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full transaction; hold = cycles of out_ready=0 in DONE,
  // disturb = pulse in_valid with junk operands mid-RUN.
  task automatic do_add(input string name, input vec_t v,
                        input int hold, input bit disturb);
    logic [W-1:0] sa, sb, sc;
    logic [W-1:0] prev;
    chk({name, " in_ready idle"}, 8'(bus.in_ready), 8'd1);
    bus.in_valid = 1'b1;
    bus.in_a     = v.a;
    bus.in_b     = v.b;
    bus.in_cin   = v.cin;
    step();
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_cin   = 1'b0;
    for (int i = 0; i < W; i++) begin
      sa[i] = bus.fa_a;
      sb[i] = bus.fa_b;
      sc[i] = bus.fa_cin;
      chk({name, " run out_valid"}, 8'(bus.out_valid), 8'd0);
      chk({name, " run in_ready"}, 8'(bus.in_ready), 8'd0);
      if (disturb && i == 1) begin
        bus.in_valid = 1'b1;
        bus.in_a     = 4'b1111;
        bus.in_b     = 4'b1111;
        bus.in_cin   = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
    end
    bus.in_valid = 1'b0;
    chk({name, " fa_a seq"}, 8'(sa), 8'(v.a));
    chk({name, " fa_b seq"}, 8'(sb), 8'(v.b));
    chk({name, " fa_cin seq"}, 8'(sc), 8'(v.cseq));
    chk({name, " latency out_valid"}, 8'(bus.out_valid), 8'd1);
    chk({name, " out_sum"}, 8'(bus.out_sum), 8'(v.sum));
    chk({name, " out_cout"}, 8'(bus.out_cout), 8'(v.cout));
    for (int k = 0; k < hold; k++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 4'b1010;
      bus.in_b     = 4'b0000;
      step();
      chk({name, " bp out_valid"}, 8'(bus.out_valid), 8'd1);
      chk({name, " bp out_sum"}, 8'(bus.out_sum), 8'(v.sum));
      chk({name, " bp out_cout"}, 8'(bus.out_cout), 8'(v.cout));
      chk({name, " bp in_ready"}, 8'(bus.in_ready), 8'd0);
      chk({name, " bp fa zero"},
          8'({bus.fa_a, bus.fa_b, bus.fa_cin}), 8'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    prev = v.sum;
    step();
    bus.out_ready = 1'b0;
    chk({name, " post out_valid"}, 8'(bus.out_valid), 8'd0);
    chk({name, " post in_ready"}, 8'(bus.in_ready), 8'd1);
    chk({name, " post out_sum held"}, 8'(bus.out_sum), 8'(prev));
    chk({name, " post out_cout held"}, 8'(bus.out_cout), 8'(v.cout));
  endtask

  initial begin
    vec_t v;
    tests  = 0;
    failed = 0;

    vecs[0] = '{4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 4'b1110};
    vecs[1] = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'b1111};
    vecs[2] = '{4'b1001, 4'b0110, 1'b1, 4'b0000, 1'b1, 4'b1111};
    vecs[3] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000};
    vecs[4] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 4'b1111};
    vecs[5] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 4'b1110};
    vecs[6] = '{4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0, 4'b0000};
    vecs[7] = '{4'b1100, 4'b1010, 1'b1, 4'b0111, 1'b1, 4'b0001};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    chk("rst out_valid", 8'(bus.out_valid), 8'd0);
    chk("rst out_sum", 8'(bus.out_sum), 8'd0);
    chk("rst out_cout", 8'(bus.out_cout), 8'd0);
    chk("rst fa", 8'({bus.fa_a, bus.fa_b, bus.fa_cin}), 8'd0);
    rst = 1'b0;
    step();
    chk("rst in_ready", 8'(bus.in_ready), 8'd1);

    for (int i = 0; i < 8; i++) begin
      do_add($sformatf("vec%0d", i), vecs[i], 0, 1'b0);
    end

    do_add("backpressure", vecs[0], 5, 1'b0);
    do_add("run_disturb", vecs[0], 0, 1'b1);

    bus.in_valid = 1'b1;
    bus.in_a     = 4'b0101;
    bus.in_b     = 4'b0011;
    bus.in_cin   = 1'b0;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst out_valid", 8'(bus.out_valid), 8'd0);
    chk("midrst out_sum", 8'(bus.out_sum), 8'd0);
    chk("midrst out_cout", 8'(bus.out_cout), 8'd0);
    chk("midrst in_ready", 8'(bus.in_ready), 8'd1);
    chk("midrst fa", 8'({bus.fa_a, bus.fa_b, bus.fa_cin}), 8'd0);
    v = vecs[2];
    do_add("after_rst", v, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
